// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one block-transfer memory path between an
// instruction-cache client (0) and a data-cache client (1), with a watchdog.
module mem_port_arbiter #(
    parameter int unsigned BLOCK_WIDTH    = 128,
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_arst,

    input  logic                   i_c0_read_req,
    input  logic                   i_c0_write_req,
    input  logic [ADDR_WIDTH-1:0]  i_c0_addr,
    input  logic [BLOCK_WIDTH-1:0] i_c0_data_block,
    output logic [BLOCK_WIDTH-1:0] o_c0_data_block,
    output logic                   o_c0_done,

    input  logic                   i_c1_read_req,
    input  logic                   i_c1_write_req,
    input  logic [ADDR_WIDTH-1:0]  i_c1_addr,
    input  logic [BLOCK_WIDTH-1:0] i_c1_data_block,
    output logic [BLOCK_WIDTH-1:0] o_c1_data_block,
    output logic                   o_c1_done,

    output logic                   o_axi_read_start,
    output logic                   o_axi_write_start,
    output logic [ADDR_WIDTH-1:0]  o_axi_addr,
    output logic [BLOCK_WIDTH-1:0] o_data_block,
    input  logic                   i_axi_done,
    input  logic [BLOCK_WIDTH-1:0] i_data_block,

    output logic [1:0]             o_grant,
    output logic                   o_timeout_fault
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_DONE    = 2'd2,
        S_RELEASE = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic                   ptr_q, ptr_d;        // id of the client served last
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]             grant_q, grant_d;
    logic                   rd_start_q, rd_start_d;
    logic                   wr_start_q, wr_start_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [BLOCK_WIDTH-1:0] wdata_q, wdata_d;
    logic [BLOCK_WIDTH-1:0] c0_rdata_q, c0_rdata_d;
    logic [BLOCK_WIDTH-1:0] c1_rdata_q, c1_rdata_d;
    logic                   c0_done_q, c0_done_d;
    logic                   c1_done_q, c1_done_d;
    logic                   fault_q, fault_d;

    logic c0_req_c;
    logic c1_req_c;
    logic pick1_c;
    logic sel_wr_c;

    // Request decode: client 1 wins when alone or when client 0 was served last
    always_comb begin
        c0_req_c = i_c0_read_req | i_c0_write_req;
        c1_req_c = i_c1_read_req | i_c1_write_req;
        pick1_c  = c1_req_c & (~c0_req_c | ~ptr_q);
        sel_wr_c = pick1_c ? i_c1_write_req : i_c0_write_req;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        rd_start_d = rd_start_q;
        wr_start_d = wr_start_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        c0_rdata_d = c0_rdata_q;
        c1_rdata_d = c1_rdata_q;
        c0_done_d  = 1'b0;
        c1_done_d  = 1'b0;
        fault_d    = fault_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (c0_req_c | c1_req_c) begin
                    grant_d    = pick1_c ? 2'b10 : 2'b01;
                    wr_start_d = sel_wr_c;
                    rd_start_d = ~sel_wr_c;
                    addr_d     = pick1_c ? i_c1_addr : i_c0_addr;
                    wdata_d    = pick1_c ? i_c1_data_block : i_c0_data_block;
                    state_d    = S_BUSY;
                end
            end

            S_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (i_axi_done) begin
                    rd_start_d = 1'b0;
                    wr_start_d = 1'b0;
                    if (rd_start_q) begin
                        if (grant_q[1]) c1_rdata_d = i_data_block;
                        else            c0_rdata_d = i_data_block;
                    end
                    c0_done_d = grant_q[0];
                    c1_done_d = grant_q[1];
                    ptr_d     = grant_q[1];
                    state_d   = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // Watchdog abort: complete the handshake but keep old data
                    rd_start_d = 1'b0;
                    wr_start_d = 1'b0;
                    fault_d    = 1'b1;
                    c0_done_d  = grant_q[0];
                    c1_done_d  = grant_q[1];
                    ptr_d      = grant_q[1];
                    state_d    = S_DONE;
                end
            end

            S_DONE: begin
                cnt_d   = '0;
                state_d = S_RELEASE;
            end

            S_RELEASE: begin
                // Hold the grant until the previous done has dropped
                if (!i_axi_done) begin
                    grant_d = 2'b00;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_arst) begin
            state_q    <= S_IDLE;
            ptr_q      <= 1'b1;
            cnt_q      <= '0;
            grant_q    <= 2'b00;
            rd_start_q <= 1'b0;
            wr_start_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            c0_rdata_q <= '0;
            c1_rdata_q <= '0;
            c0_done_q  <= 1'b0;
            c1_done_q  <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            rd_start_q <= rd_start_d;
            wr_start_q <= wr_start_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            c0_rdata_q <= c0_rdata_d;
            c1_rdata_q <= c1_rdata_d;
            c0_done_q  <= c0_done_d;
            c1_done_q  <= c1_done_d;
            fault_q    <= fault_d;
        end
    end

    assign o_c0_data_block   = c0_rdata_q;
    assign o_c0_done         = c0_done_q;
    assign o_c1_data_block   = c1_rdata_q;
    assign o_c1_done         = c1_done_q;
    assign o_axi_read_start  = rd_start_q;
    assign o_axi_write_start = wr_start_q;
    assign o_axi_addr        = addr_q;
    assign o_data_block      = wdata_q;
    assign o_grant           = grant_q;
    assign o_timeout_fault   = fault_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

    localparam int unsigned BW = 128;
    localparam int unsigned AW = 64;
    localparam int unsigned TO = 16;

    logic          i_clk = 1'b0;
    logic          i_arst;
    logic          i_c0_read_req, i_c0_write_req;
    logic [AW-1:0] i_c0_addr;
    logic [BW-1:0] i_c0_data_block, o_c0_data_block;
    logic          o_c0_done;
    logic          i_c1_read_req, i_c1_write_req;
    logic [AW-1:0] i_c1_addr;
    logic [BW-1:0] i_c1_data_block, o_c1_data_block;
    logic          o_c1_done;
    logic          o_axi_read_start, o_axi_write_start;
    logic [AW-1:0] o_axi_addr;
    logic [BW-1:0] o_data_block;
    logic          i_axi_done;
    logic [BW-1:0] i_data_block;
    logic [1:0]    o_grant;
    logic          o_timeout_fault;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [BW-1:0] exp_d0, exp_d1;

    always #5 i_clk = ~i_clk;

    mem_port_arbiter #(
        .BLOCK_WIDTH(BW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(i_clk), .i_arst(i_arst),
        .i_c0_read_req(i_c0_read_req), .i_c0_write_req(i_c0_write_req),
        .i_c0_addr(i_c0_addr), .i_c0_data_block(i_c0_data_block),
        .o_c0_data_block(o_c0_data_block), .o_c0_done(o_c0_done),
        .i_c1_read_req(i_c1_read_req), .i_c1_write_req(i_c1_write_req),
        .i_c1_addr(i_c1_addr), .i_c1_data_block(i_c1_data_block),
        .o_c1_data_block(o_c1_data_block), .o_c1_done(o_c1_done),
        .o_axi_read_start(o_axi_read_start), .o_axi_write_start(o_axi_write_start),
        .o_axi_addr(o_axi_addr), .o_data_block(o_data_block),
        .i_axi_done(i_axi_done), .i_data_block(i_data_block),
        .o_grant(o_grant), .o_timeout_fault(o_timeout_fault)
    );

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Synchronous reset edge; leaves the DUT in IDLE with reset released
    task automatic do_reset();
        i_arst = 1'b0;
        step();
        chk("rst_grant", BW'(o_grant), BW'(0));
        chk("rst_flags", BW'({o_axi_read_start, o_axi_write_start, o_c0_done, o_c1_done, o_timeout_fault}), BW'(0));
        chk("rst_addr", BW'(o_axi_addr), BW'(0));
        chk("rst_wdata", o_data_block, BW'(0));
        chk("rst_d0", o_c0_data_block, BW'(0));
        chk("rst_d1", o_c1_data_block, BW'(0));
        i_arst = 1'b1;
        exp_d0 = '0;
        exp_d1 = '0;
    endtask

    // Grant edge through completion edge; returns with the DUT in DONE
    task automatic do_xfer(input string tag, input logic [1:0] g, input logic wr,
                           input logic [AW-1:0] a, input logic [BW-1:0] wd,
                           input int n_busy, input logic [BW-1:0] rd, input bit keep_done);
        int hi;
        step();
        chk({tag, "_grant"}, BW'(o_grant), BW'(g));
        chk({tag, "_start"}, BW'({o_axi_read_start, o_axi_write_start}), BW'({~wr, wr}));
        chk({tag, "_addr"}, BW'(o_axi_addr), BW'(a));
        chk({tag, "_wdata"}, o_data_block, wd);
        hi = 0;
        for (int i = 0; i < n_busy - 1; i++) begin
            hi += int'(o_axi_read_start | o_axi_write_start);
            step();
        end
        i_c0_addr = ~i_c0_addr;
        i_c1_addr = ~i_c1_addr;
        #1;
        chk({tag, "_addr_hold"}, BW'(o_axi_addr), BW'(a));
        i_axi_done   = 1'b1;
        i_data_block = rd;
        hi += int'(o_axi_read_start | o_axi_write_start);
        step();
        i_c0_addr = ~i_c0_addr;
        i_c1_addr = ~i_c1_addr;
        if (!keep_done) i_axi_done = 1'b0;
        chk({tag, "_start_len"}, BW'(hi), BW'(n_busy));
        chk({tag, "_start_off"}, BW'({o_axi_read_start, o_axi_write_start}), BW'(0));
        chk({tag, "_done"}, BW'({o_c1_done, o_c0_done}), BW'(g));
        chk({tag, "_grant_held"}, BW'(o_grant), BW'(g));
        if (!wr) begin
            if (g[0]) exp_d0 = rd;
            else      exp_d1 = rd;
        end
        chk({tag, "_d0"}, o_c0_data_block, exp_d0);
        chk({tag, "_d1"}, o_c1_data_block, exp_d1);
    endtask

    // DONE -> RELEASE -> IDLE with i_axi_done low
    task automatic finish_xfer(input string tag, input logic [1:0] g);
        step();
        chk({tag, "_done_pulse"}, BW'({o_c1_done, o_c0_done}), BW'(0));
        chk({tag, "_rel_grant"}, BW'(o_grant), BW'(g));
        step();
        chk({tag, "_idle_grant"}, BW'(o_grant), BW'(0));
        chk({tag, "_idle_start"}, BW'({o_axi_read_start, o_axi_write_start}), BW'(0));
    endtask

    initial begin
        logic [BW-1:0] pat_a5;
        int cnt;
        pat_a5 = {4{32'hA5A5_A5A5}};
        i_arst = 1'b0;
        i_c0_read_req = 1'b0; i_c0_write_req = 1'b0; i_c0_addr = '0; i_c0_data_block = '0;
        i_c1_read_req = 1'b0; i_c1_write_req = 1'b0; i_c1_addr = '0; i_c1_data_block = '0;
        i_axi_done = 1'b0; i_data_block = '0;
        step();
        do_reset();

        // Single client 0 read, 8-cycle transfer
        i_c0_read_req = 1'b1; i_c0_addr = 64'h1000; i_c0_data_block = BW'(128'h11);
        do_xfer("t1", 2'b01, 1'b0, 64'h1000, BW'(128'h11), 8, pat_a5, 1'b0);
        i_c0_read_req = 1'b0;
        finish_xfer("t1", 2'b01);

        // Simultaneous reads after reset, twice: 0 then 1 each round
        do_reset();
        for (int r = 0; r < 2; r++) begin
            i_c0_read_req = 1'b1; i_c0_addr = 64'h100; i_c0_data_block = BW'(128'h22);
            i_c1_read_req = 1'b1; i_c1_addr = 64'h200; i_c1_data_block = BW'(128'h33);
            do_xfer("t2_c0", 2'b01, 1'b0, 64'h100, BW'(128'h22), 3 + r, BW'(128'hC0DE_0000 + r), 1'b0);
            i_c0_read_req = 1'b0;
            finish_xfer("t2_c0", 2'b01);
            do_xfer("t2_c1", 2'b10, 1'b0, 64'h200, BW'(128'h33), 4 + r, BW'(128'hC1DE_0000 + r), 1'b0);
            i_c1_read_req = 1'b0;
            finish_xfer("t2_c1", 2'b10);
        end

        // Client 1 write and read together: write first, read on a later IDLE sample
        i_c1_write_req = 1'b1; i_c1_read_req = 1'b1;
        i_c1_addr = 64'h2000; i_c1_data_block = {4{32'hDEAD_BEEF}};
        do_xfer("t3_wr", 2'b10, 1'b1, 64'h2000, {4{32'hDEAD_BEEF}}, 5, BW'(128'hBAD), 1'b0);
        i_c1_write_req = 1'b0;
        finish_xfer("t3_wr", 2'b10);
        do_xfer("t3_rd", 2'b10, 1'b0, 64'h2000, {4{32'hDEAD_BEEF}}, 2, BW'(128'h5EED), 1'b0);
        i_c1_read_req = 1'b0;
        finish_xfer("t3_rd", 2'b10);

        // Watchdog: done never arrives
        i_c0_read_req = 1'b1; i_c0_addr = 64'h3000; i_c0_data_block = BW'(128'h44);
        step();
        chk("t4_grant", BW'(o_grant), BW'(2'b01));
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (o_c0_done) break;
            cnt += int'(o_axi_read_start);
            step();
        end
        chk("t4_start_len", BW'(cnt), BW'(TO));
        chk("t4_done", BW'(o_c0_done), BW'(1));
        chk("t4_fault", BW'(o_timeout_fault), BW'(1));
        chk("t4_d0", o_c0_data_block, exp_d0);
        i_c0_read_req = 1'b0;
        finish_xfer("t4", 2'b01);
        chk("t4_fault_sticky", BW'(o_timeout_fault), BW'(1));
        i_c0_read_req = 1'b1; i_c0_addr = 64'h3100; i_c0_data_block = BW'(128'h55);
        do_xfer("t4_next", 2'b01, 1'b0, 64'h3100, BW'(128'h55), 3, BW'(128'h77), 1'b0);
        i_c0_read_req = 1'b0;
        finish_xfer("t4_next", 2'b01);
        chk("t4_fault_kept", BW'(o_timeout_fault), BW'(1));

        // Reset mid-transfer, with client 0 also requesting at release
        i_c1_read_req = 1'b1; i_c1_addr = 64'h4000; i_c1_data_block = BW'(128'h66);
        step();
        chk("t5_grant", BW'(o_grant), BW'(2'b10));
        step();
        i_c0_read_req = 1'b1; i_c0_addr = 64'h5000; i_c0_data_block = BW'(128'h88);
        do_reset();
        do_xfer("t5_c0", 2'b01, 1'b0, 64'h5000, BW'(128'h88), 2, BW'(128'h99), 1'b0);
        i_c0_read_req = 1'b0;
        finish_xfer("t5_c0", 2'b01);
        do_xfer("t5_c1", 2'b10, 1'b0, 64'h4000, BW'(128'h66), 2, BW'(128'hAA), 1'b0);
        i_c1_read_req = 1'b0;
        finish_xfer("t5_c1", 2'b10);
        // Reset mid-transfer with only client 1 pending
        i_c1_read_req = 1'b1;
        step();
        step();
        do_reset();
        do_xfer("t5_solo", 2'b10, 1'b0, 64'h4000, BW'(128'h66), 2, BW'(128'hBB), 1'b0);
        i_c1_read_req = 1'b0;
        finish_xfer("t5_solo", 2'b10);

        // Stale done held 3 extra cycles keeps the arbiter in RELEASE
        i_c0_read_req = 1'b1; i_c0_addr = 64'h6000; i_c0_data_block = BW'(128'hCC);
        i_c1_read_req = 1'b1; i_c1_addr = 64'h7000; i_c1_data_block = BW'(128'hDD);
        do_xfer("t6", 2'b01, 1'b0, 64'h6000, BW'(128'hCC), 3, BW'(128'hEE), 1'b1);
        i_c0_read_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t6_hold_grant", BW'(o_grant), BW'(2'b01));
            chk("t6_hold_start", BW'({o_axi_read_start, o_axi_write_start}), BW'(0));
        end
        i_axi_done = 1'b0;
        step();
        chk("t6_idle_grant", BW'(o_grant), BW'(0));
        do_xfer("t6_c1", 2'b10, 1'b0, 64'h7000, BW'(128'hDD), 2, BW'(128'hFF), 1'b0);
        i_c1_read_req = 1'b0;
        finish_xfer("t6_c1", 2'b10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
